// File: rtl/pio_pkg.sv
// Shared constants for the input PIO: Avalon register map and edge selection.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pio_pkg;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Per-bit edge qualifier; anything other than falling/any behaves as rising.
  function automatic logic edge_bit(input int edge_type, input logic cur, input logic prev);
    if (edge_type == EDGE_FALLING) return ~cur & prev;
    else if (edge_type == EDGE_ANY) return cur ^ prev;
    else return cur & ~prev;
  endfunction

endpackage

// File: rtl/pio_in_edge_capture_if.sv
// Avalon-MM slave bus bundle for the input PIO (address/strobes/data).
// Latency: readdata valid one clk after a read strobe (readLatency = 1).
// Backpressure: none; the slave never stalls, so no waitrequest.
interface pio_in_edge_capture_if;
  import pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read_n;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/pio_in_edge_capture_bit_synchronizer.sv
// Multi-bit flop synchronizer for asynchronous inputs, each bit independent.
// Latency: STAGES clks from d to q.
// Backpressure: none; free-running every clk.
module bit_synchronizer #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the raw input through the flop chain; whole chain clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/pio_in_edge_capture.sv
// Avalon-MM input PIO: synchronizes in_port, latches per-bit edges, raises maskable irq.
// Latency: in_port change -> edgecapture SYNC_STAGES+1 clks, irq one clk later; readdata 1 clk.
// Backpressure: none; reads and writes complete every cycle they are strobed.
module pio_in_edge_capture
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_in_edge_capture_if.slave  bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0]  sync_q;
  logic [WIDTH-1:0]  prev_q;
  logic [WIDTH-1:0]  edge_v;
  logic [WIDTH-1:0]  clear_v;
  logic [WIDTH-1:0]  edgecap_q;
  logic [WIDTH-1:0]  irqmask_q;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] readdata_q;
  logic              wr_en;
  logic              rd_en;
  logic              unused_wdata;

  bit_synchronizer #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_q)
  );

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign rd_en = bus.chipselect & ~bus.read_n;

  // Upper writedata bits beyond WIDTH carry nothing for this block.
  assign unused_wdata = ^bus.writedata;

  // Per-bit edge qualify on the synchronized sample vs. its one-clk-old copy.
  always_comb begin
    edge_v = '0;
    for (int i = 0; i < WIDTH; i++) edge_v[i] = edge_bit(EDGE_TYPE, sync_q[i], prev_q[i]);
  end

  // Write-1-to-clear mask for edgecapture, only on an address-3 write.
  always_comb begin
    clear_v = '0;
    if (wr_en && bus.address == ADDR_EDGECAP) clear_v = bus.writedata[WIDTH-1:0];
  end

  // Read mux; unused upper bits and the reserved word read as zero.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_q;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap_q;
      default:      rd_mux = '0;
    endcase
  end

  // Edge history, capture (new edge beats a same-cycle clear), mask and irq.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      edgecap_q <= '0;
      irqmask_q <= RESET_MASK;
      irq       <= 1'b0;
    end else begin
      prev_q    <= sync_q;
      edgecap_q <= edge_v | (edgecap_q & ~clear_v);
      if (wr_en && bus.address == ADDR_IRQMASK) irqmask_q <= bus.writedata[WIDTH-1:0];
      irq       <= |(edgecap_q & irqmask_q);
    end
  end

  // Registered read data; samples pre-write state and holds between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else if (rd_en) readdata_q <= rd_mux;
  end

  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Scoreboard bench for pio_in_edge_capture: a rising-edge and a falling-edge instance.
// Stimulus pushes expected readdata/irq; a monitor pops when the response is due.
// All bus ops drive just after negedge; responses are sampled at the following negedge.
module tb_pio_in_edge_capture;
  import pio_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in0, in1;
  logic       irq0, irq1;

  always #5 clk = ~clk;

  pio_in_edge_capture_if bus0 ();
  pio_in_edge_capture_if bus1 ();

  pio_in_edge_capture #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_MASK(4'h0)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0),
    .in_port (in0),
    .irq     (irq0)
  );

  pio_in_edge_capture #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(1), .RESET_MASK(4'h0)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1),
    .in_port (in1),
    .irq     (irq1)
  );

  typedef struct {
    int          dut;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [1:0] rd_vld;
  logic [1:0] irq_vld;
  logic [1:0] irq_req = 2'b00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Mark which responses land at the next negedge.
  always @(posedge clk) begin
    rd_vld[0] <= bus0.chipselect & ~bus0.read_n;
    rd_vld[1] <= bus1.chipselect & ~bus1.read_n;
    irq_vld   <= irq_req;
  end

  // Monitor: pop and compare whenever a response is due.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rd_vld[d] === 1'b1) begin
        if (rd_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_read dut%0d", d);
        end else begin
          e = rd_q.pop_front();
          check(e.nm, (d == 0) ? bus0.readdata : bus1.readdata, (e.dut == d) ? e.val : 32'hDEAD_BEEF);
        end
      end
      if (irq_vld[d] === 1'b1) begin
        if (irq_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_irq_check dut%0d", d);
        end else begin
          e = irq_q.pop_front();
          check(e.nm, {31'b0, (d == 0) ? irq0 : irq1}, (e.dut == d) ? e.val : 32'hDEAD_BEEF);
        end
      end
    end
  end

  task automatic bus_idle();
    bus0.chipselect = 1'b0; bus0.read_n = 1'b1; bus0.write_n = 1'b1;
    bus0.address = 2'd0; bus0.writedata = 32'h0;
    bus1.chipselect = 1'b0; bus1.read_n = 1'b1; bus1.write_n = 1'b1;
    bus1.address = 2'd0; bus1.writedata = 32'h0;
  endtask

  // One bus cycle on DUT d; expectations refer to values after the next posedge.
  task automatic op(input int d, input bit wr, input bit rd, input logic [1:0] a,
                    input logic [31:0] wd, input logic [31:0] erd,
                    input bit ci, input bit eirq, input string nm);
    if (d == 0) begin
      bus0.chipselect = 1'b1; bus0.read_n = ~rd; bus0.write_n = ~wr;
      bus0.address = a; bus0.writedata = wd;
    end else begin
      bus1.chipselect = 1'b1; bus1.read_n = ~rd; bus1.write_n = ~wr;
      bus1.address = a; bus1.writedata = wd;
    end
    if (rd) rd_q.push_back('{d, erd, nm});
    if (ci) begin
      irq_q.push_back('{d, {31'b0, eirq}, {nm, "_irq"}});
      irq_req[d] = 1'b1;
    end
    @(negedge clk);
    bus_idle();
    irq_req = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input int d, input logic [1:0] a, input logic [31:0] e, input string nm);
    op(d, 1'b0, 1'b1, a, 32'h0, e, 1'b0, 1'b0, nm);
  endtask

  task automatic rdi(input int d, input logic [1:0] a, input logic [31:0] e, input bit ei, input string nm);
    op(d, 1'b0, 1'b1, a, 32'h0, e, 1'b1, ei, nm);
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] wd, input string nm);
    op(d, 1'b1, 1'b0, a, wd, 32'h0, 1'b0, 1'b0, nm);
  endtask

  task automatic wri(input int d, input logic [1:0] a, input logic [31:0] wd, input bit ei, input string nm);
    op(d, 1'b1, 1'b0, a, wd, 32'h0, 1'b1, ei, nm);
  endtask

  initial begin
    bus_idle();
    reset_n = 1'b0;
    in0 = 4'h0;
    in1 = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_irq0", {31'b0, irq0}, 32'h0);
    check("rst_readdata0", bus0.readdata, 32'h0);
    reset_n = 1'b1;

    // Reset values of every register, reserved word and RO data ignore writes.
    rd (0, ADDR_DATA,    32'h0, "t1_data");
    rd (0, ADDR_RSVD,    32'h0, "t1_rsvd");
    rd (0, ADDR_IRQMASK, 32'h0, "t1_mask");
    rdi(0, ADDR_EDGECAP, 32'h0, 1'b0, "t1_ecap");
    rd (1, ADDR_EDGECAP, 32'h0, "t1_ecap_d1");
    wr (0, ADDR_RSVD, 32'hFFFF_FFFF, "t1_wr_rsvd");
    rd (0, ADDR_RSVD, 32'h0, "t1_rsvd_after_wr");
    wr (0, ADDR_DATA, 32'hF, "t1_wr_data");
    rd (0, ADDR_DATA, 32'h0, "t1_data_after_wr");

    // Rising capture: edgecapture after exactly 3 clks, irq after 4.
    wr (0, ADDR_IRQMASK, 32'hF, "t2_mask_wr");
    in0 = 4'h5;
    idle(2);
    rdi(0, ADDR_EDGECAP, 32'h0, 1'b0, "t2_ecap_clk3");
    rdi(0, ADDR_EDGECAP, 32'h5, 1'b1, "t2_ecap_clk4");
    rd (0, ADDR_DATA,    32'h5, "t2_data");
    rd (0, ADDR_IRQMASK, 32'hF, "t2_mask_rd");

    // W1C: partial clear keeps irq, full clear drops it one clk later.
    wri(0, ADDR_EDGECAP, 32'h1, 1'b1, "t3_clr_b0");
    rdi(0, ADDR_EDGECAP, 32'h4, 1'b1, "t3_ecap_4");
    wri(0, ADDR_EDGECAP, 32'h4, 1'b1, "t3_clr_b2");
    rdi(0, ADDR_EDGECAP, 32'h0, 1'b0, "t3_ecap_0");

    // Clear and new edge on bit 0 in the same cycle: set wins.
    in0 = 4'h4;
    idle(4);
    in0 = 4'h5;
    idle(4);
    rd (0, ADDR_EDGECAP, 32'h1, "t4_setup");
    in0 = 4'h4;
    idle(4);
    in0 = 4'h5;
    idle(2);
    wr (0, ADDR_EDGECAP, 32'h1, "t4_clr_vs_edge");
    rd (0, ADDR_EDGECAP, 32'h1, "t4_set_wins");
    wr (0, ADDR_EDGECAP, 32'h1, "t4_clr_plain");
    rd (0, ADDR_EDGECAP, 32'h0, "t4_cleared");

    // Falling-edge instance, masked capture, then mask on/off.
    in1 = 4'hF;
    idle(4);
    rd (1, ADDR_EDGECAP, 32'h0, "t5_no_fall");
    in1 = 4'hE;
    idle(3);
    rdi(1, ADDR_EDGECAP, 32'h1, 1'b0, "t5_ecap");
    wri(1, ADDR_IRQMASK, 32'h1, 1'b0, "t5_mask_wr");
    rdi(1, ADDR_IRQMASK, 32'h1, 1'b1, "t5_irq_on");
    op (1, 1'b1, 1'b1, ADDR_IRQMASK, 32'h3, 32'h1, 1'b0, 1'b0, "t5_rw_same");
    rd (1, ADDR_IRQMASK, 32'h3, "t5_mask_new");
    wri(1, ADDR_IRQMASK, 32'h0, 1'b1, "t5_mask_off");
    rdi(1, ADDR_EDGECAP, 32'h1, 1'b0, "t5_ecap_kept");

    // Mid-operation reset clears everything; rising edge from reset release.
    in0 = 4'h0;
    idle(4);
    wr (0, ADDR_EDGECAP, 32'hF, "t6_pre_clr");
    in0 = 4'h3;
    idle(4);
    rdi(0, ADDR_EDGECAP, 32'h3, 1'b1, "t6_ecap3");
    #2;
    reset_n = 1'b0;
    in0 = 4'h1;
    #1;
    check("t6_rst_readdata0", bus0.readdata, 32'h0);
    check("t6_rst_irq0", {31'b0, irq0}, 32'h0);
    check("t6_rst_readdata1", bus1.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    rdi(0, ADDR_EDGECAP, 32'h0, 1'b0, "t6_ecap_clk3");
    rdi(0, ADDR_EDGECAP, 32'h1, 1'b0, "t6_ecap_clk4");
    rd (0, ADDR_IRQMASK, 32'h0, "t6_mask_rst");

    idle(2);
    n_tests++;
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d reads and %0d irq checks pending, expected 0", rd_q.size(), irq_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_in_edge_capture.md
Name: pio_in_edge_capture

Overview:
- Avalon-MM input PIO slave. It samples an external input bus such as the HPI interrupt line or a status pin, synchronizes it, and detects edges per bit.
- Latched edges raise a maskable interrupt to the Nios II through the SoC interconnect.
- It is the read-direction counterpart of the single-bit output PIOs that drive the OTG HPI control lines: software reads pins and events instead of writing them.

Parameters:
- WIDTH, 1: number of input bits, 1..32.
- SYNC_STAGES, 2: flip-flop synchronizer depth on in_port, 2..3.
- EDGE_TYPE, 0: edge to capture. 0 = rising, 1 = falling, 2 = any.
- RESET_MASK, 0: reset value of irqmask, WIDTH bits.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon chip select.
- read_n  in  1  Avalon read strobe, active low.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  32  Avalon write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  Avalon read data, registered.
- irq  out  1  level interrupt, active high.

Behaviour:
- Register map:
  - 0 = data (RO): synchronized input.
  - 1 = reserved: reads 0, writes ignored.
  - 2 = irqmask (RW).
  - 3 = edgecapture (RW1C).
- Unused upper bits of every register read 0.
- Reset (async, on reset_n low):
  - synchronizer chain = 0, previous-sample register = 0.
  - edgecapture = 0, irqmask = RESET_MASK.
  - readdata = 0, irq = 0.
- Synchronizer: in_port passes through SYNC_STAGES flops. sync_q is the last stage; prev_q is sync_q delayed one clk.
- Edge detect, per bit, in the cycle sync_q and prev_q differ:
  - rising = sync_q & ~prev_q.
  - falling = ~sync_q & prev_q.
  - any = the XOR of sync_q and prev_q.
- Total latency from an in_port change to the edgecapture bit set is SYNC_STAGES+1 clocks.
- edgecapture update, each bit each cycle:
  - next = edge_bit | (cur & ~clear_bit).
  - clear_bit = chipselect & ~write_n & address==3 & writedata[bit].
  - If an edge and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Writes to address 0 are ignored.
- Write to address 2: irqmask <= writedata[WIDTH-1:0].
- Read: when chipselect & ~read_n, readdata is registered on the next clk edge from the mux at the current address (1-cycle read latency; the interconnect is configured for readLatency = 1).
  - readdata holds its value when no read is in progress.
  - A read does not clear edgecapture.
- irq is registered: irq <= |(edgecapture & irqmask), so it asserts one clk after the bit latches.
- irq stays high until software clears every masked set bit. Masking a set bit drops irq one clk later, with no loss of the captured bit.
- Read and write in the same cycle at the same address: the read returns the pre-write value.
- reset_n asserted mid-operation: all state is cleared immediately, and pending edges are lost.
- in_port held constant: no edge is generated. An edge resulting from reset release with in_port = 1 is a legitimate rising edge after SYNC_STAGES+1 clocks (prev_q starts at 0).
- Pulses shorter than one clk period may be missed. This is acceptable and not required to be caught.

Decomposition:
- Shared package pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - edge-type constants EDGE_RISING/EDGE_FALLING/EDGE_ANY.
- One sub-module, bit_synchronizer: WIDTH-wide, SYNC_STAGES-deep, async active-low reset. It is reused by the other input-facing blocks.
- Edge logic, register file and read mux stay in the top level.

Test Plan:
1. Reset, then read all four addresses, with RESET_MASK=0 → readdata 0x0 for each; irq=0.
2. WIDTH=4, EDGE_TYPE=0, irqmask=0xF. Drive in_port 0x0→0x5 → edgecapture=0x5 at exactly 3 clks; irq=1 at 4 clks. Read addr 0 → 0x5.
3. With edgecapture=0x5, write 0x1 to addr 3 → edgecapture=0x4 and irq stays 1. Write 0x4 → edgecapture=0x0 and irq=0 one clk later.
4. Clear bit 0 via addr-3 write in the same cycle a new rising edge on bit 0 reaches edge detect → bit 0 remains 1.
5. EDGE_TYPE=1, irqmask=0x0. Drive in_port 0xF→0xE → edgecapture=0x1, irq=0. Then write irqmask=0x1 → irq=1 next clk.
6. Assert reset_n low mid-capture with edgecapture=0x3 → edgecapture, irq and readdata=0 immediately. Release with in_port=0x1 → edgecapture bit 0 set 3 clks after release (EDGE_TYPE=0).
